// File: rtl/opc_history_ctl.sv
// opc_history_ctl: old-PC history controller.
//   Keeps a DEPTH-deep ring of captured PCs, advanced on fetch/opcclk unless
//   inhibited. A PC-match trigger freezes the history after trig_post further
//   captures. The spy side reads entries by age via rd_req / rd_ack.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   state_fetch, opcclk     capture requests
//   opcinh                  inhibit captures
//   pc                      PC to capture
//   trig_en/trig_pc/trig_post  trigger enable, match PC, post-trigger captures
//   rearm                   clear fill and return to ARMED
//   rd_req/rd_idx           read request, age index (0 = newest)
//   rd_ack/rd_data          one-cycle read strobe and data
//   opc                     most recently captured PC
//   fill                    valid entry count (saturates at DEPTH)
//   frozen                  history frozen
module opc_history_ctl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PCW   = 14,
  parameter int unsigned IDXW  = 3,
  parameter int unsigned POSTW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             state_fetch,
  input  logic             opcclk,
  input  logic             opcinh,
  input  logic [PCW-1:0]   pc,
  input  logic             trig_en,
  input  logic [PCW-1:0]   trig_pc,
  input  logic [POSTW-1:0] trig_post,
  input  logic             rearm,
  input  logic             rd_req,
  input  logic [IDXW-1:0]  rd_idx,
  output logic             rd_ack,
  output logic [PCW-1:0]   rd_data,
  output logic [PCW-1:0]   opc,
  output logic [IDXW:0]    fill,
  output logic             frozen
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    POST   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  localparam logic [IDXW:0] FULL = (IDXW+1)'(DEPTH);

  state_t           state;
  logic [PCW-1:0]   ring [DEPTH];
  logic [IDXW-1:0]  wp;
  logic [POSTW-1:0] cnt;

  logic             cap;
  logic             match;
  logic             rd_accept;
  logic             rd_hit;
  logic [IDXW-1:0]  rd_pos;

  // rearm wins over capture; nothing is captured once frozen
  assign cap       = (state_fetch | opcclk) & ~opcinh & (state != FROZEN) & ~rearm;
  assign match     = trig_en & (pc == trig_pc);
  // a new request is taken only while no ack is being presented
  assign rd_accept = rd_req & ~rd_ack;
  // age index to ring slot; wraps naturally since DEPTH is a power of 2
  assign rd_pos    = wp - IDXW'(1) - rd_idx;
  assign rd_hit    = {1'b0, rd_idx} < fill;
  assign frozen    = (state == FROZEN);

  // history storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) ring[i] <= '0;
    end else if (cap) begin
      ring[wp] <= pc;
    end
  end

  // write pointer, fill, trigger FSM and read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ARMED;
      wp      <= '0;
      opc     <= '0;
      fill    <= '0;
      cnt     <= '0;
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      // read uses pre-capture ring and wp
      if (rd_accept) begin
        rd_ack  <= 1'b1;
        rd_data <= rd_hit ? ring[rd_pos] : '0;
      end else begin
        rd_ack  <= 1'b0;
      end

      if (rearm) begin
        state <= ARMED;
        cnt   <= '0;
        fill  <= '0;
      end else if (cap) begin
        wp   <= wp + IDXW'(1);
        opc  <= pc;
        fill <= (fill == FULL) ? fill : fill + (IDXW+1)'(1);
        case (state)
          ARMED: begin
            if (match) begin
              if (trig_post == '0) begin
                state <= FROZEN;
              end else begin
                state <= POST;
                cnt   <= trig_post;
              end
            end
          end
          POST: begin
            cnt <= cnt - POSTW'(1);
            if (cnt == POSTW'(1)) state <= FROZEN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_opc_history_ctl.sv
// Scoreboard bench for opc_history_ctl: read expectations are queued at
// request time and checked by an independent monitor on rd_ack; status
// outputs are checked directly at negedge.
module tb_opc_history_ctl;

  localparam int unsigned PCW   = 14;
  localparam int unsigned IDXW  = 3;
  localparam int unsigned POSTW = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             state_fetch = 1'b0;
  logic             opcclk = 1'b0;
  logic             opcinh = 1'b0;
  logic [PCW-1:0]   pc = '0;
  logic             trig_en = 1'b0;
  logic [PCW-1:0]   trig_pc = '0;
  logic [POSTW-1:0] trig_post = '0;
  logic             rearm = 1'b0;
  logic             rd_req = 1'b0;
  logic [IDXW-1:0]  rd_idx = '0;
  logic             rd_ack;
  logic [PCW-1:0]   rd_data;
  logic [PCW-1:0]   opc;
  logic [IDXW:0]    fill;
  logic             frozen;

  opc_history_ctl #(.DEPTH(8), .PCW(PCW), .IDXW(IDXW), .POSTW(POSTW)) dut (
    .clk(clk), .reset(reset), .state_fetch(state_fetch), .opcclk(opcclk),
    .opcinh(opcinh), .pc(pc), .trig_en(trig_en), .trig_pc(trig_pc),
    .trig_post(trig_post), .rearm(rearm), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_ack(rd_ack), .rd_data(rd_data), .opc(opc), .fill(fill), .frozen(frozen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PCW-1:0] data;
    int             due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every rd_ack must match the oldest queued expectation, on time
  always @(negedge clk) begin
    exp_t e;
    if (rd_ack) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rd_ack_unexpected: got rd_ack=1 rd_data=%h at cycle %0d, required no ack", rd_data, cyc);
      end else begin
        e = q.pop_front();
        n_cmp++;
        if (rd_data !== e.data) begin
          n_err++;
          $display("FAIL rd_data: got %h, required %h", rd_data, e.data);
        end
        n_cmp++;
        if (cyc != e.due) begin
          n_err++;
          $display("FAIL rd_latency: ack at cycle %0d, required %0d", cyc, e.due);
        end
      end
    end else if (q.size() != 0 && q[0].due < cyc) begin
      e = q.pop_front();
      n_cmp++; n_err++;
      $display("FAIL rd_ack_missing: no ack by cycle %0d, required at %0d (data %h)", cyc, e.due, e.data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // all tasks start and end at a falling edge
  task automatic fetch(input logic [PCW-1:0] p);
    state_fetch = 1'b1; pc = p;
    @(negedge clk);
    state_fetch = 1'b0;
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
  endtask

  task automatic rd(input logic [IDXW-1:0] idx, input logic [PCW-1:0] exp);
    exp_t e;
    rd_req = 1'b1; rd_idx = idx;
    e.data = exp; e.due = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // reset state
    #2;
    check("rst_opc", 32'(opc), 32'h0);
    check("rst_fill", 32'(fill), 32'h0);
    check("rst_frozen", 32'(frozen), 32'h0);
    check("rst_rd_ack", 32'(rd_ack), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: ten fetches, ring wraps, fill saturates
    for (int i = 1; i <= 10; i++) fetch(PCW'(i));
    check("t1_fill", 32'(fill), 32'd8);
    check("t1_opc", 32'(opc), 32'd10);
    rd(3'd0, 14'd10);
    rd(3'd7, 14'd3);
    rd(3'd3, 14'd7);

    // 2: inhibited capture is skipped; opcclk also captures
    do_rearm();
    check("t2_rearm_fill", 32'(fill), 32'd0);
    fetch(14'd4);
    opcinh = 1'b1; fetch(14'd5); opcinh = 1'b0;
    opcclk = 1'b1; pc = 14'd6; @(negedge clk); opcclk = 1'b0;
    check("t2_fill", 32'(fill), 32'd2);
    check("t2_opc", 32'(opc), 32'd6);
    rd(3'd0, 14'd6);
    rd(3'd1, 14'd4);
    rd(3'd2, 14'd0);   // beyond fill reads 0 even though the slot holds old data

    // 3: trigger with two post-trigger captures
    do_rearm();
    trig_en = 1'b1; trig_pc = 14'h100; trig_post = 4'd2;
    fetch(14'h0FF);
    fetch(14'h100);
    check("t3_post_frozen0", 32'(frozen), 32'h0);
    fetch(14'h101);
    check("t3_post_frozen1", 32'(frozen), 32'h0);
    fetch(14'h102);
    check("t3_frozen", 32'(frozen), 32'h1);
    fetch(14'h103);
    check("t3_opc", 32'(opc), 32'h102);
    check("t3_fill", 32'(fill), 32'd4);
    rd(3'd0, 14'h102);
    rd(3'd1, 14'h101);

    // 4: freeze on match, rearm with a suppressed same-cycle capture
    do_rearm();
    check("t4_unfrozen", 32'(frozen), 32'h0);
    trig_pc = 14'h2A; trig_post = 4'd0;
    fetch(14'h29);
    check("t4_pre_frozen", 32'(frozen), 32'h0);
    fetch(14'h2A);
    check("t4_frozen", 32'(frozen), 32'h1);
    check("t4_opc", 32'(opc), 32'h2A);
    state_fetch = 1'b1; pc = 14'h3FF; rearm = 1'b1;
    @(negedge clk);
    state_fetch = 1'b0; rearm = 1'b0;
    check("t4_rearm_frozen", 32'(frozen), 32'h0);
    check("t4_rearm_fill", 32'(fill), 32'd0);
    check("t4_rearm_opc", 32'(opc), 32'h2A);
    rd(3'd0, 14'h0);
    trig_en = 1'b0;

    // 5: read concurrent with capture sees old newest; held request re-accepted 2 cycles on
    fetch(14'h54);
    state_fetch = 1'b1; pc = 14'h55; rd_req = 1'b1; rd_idx = 3'd0;
    e.data = 14'h54; e.due = cyc + 1; q.push_back(e);
    @(negedge clk);
    state_fetch = 1'b0;
    @(negedge clk);
    e.data = 14'h55; e.due = cyc + 1; q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    check("t5_opc", 32'(opc), 32'h55);

    // 6: reset during POST with a read in flight
    trig_en = 1'b1; trig_pc = 14'h200; trig_post = 4'd3;
    fetch(14'h200);
    fetch(14'h201);
    check("t6_in_post", 32'(frozen), 32'h0);
    rd_req = 1'b1; rd_idx = 3'd0;
    @(posedge clk);
    #1;
    reset = 1'b1; rd_req = 1'b0;
    #1;
    check("t6_ack_drop", 32'(rd_ack), 32'h0);
    @(negedge clk);
    check("t6_opc", 32'(opc), 32'h0);
    check("t6_fill", 32'(fill), 32'h0);
    check("t6_rd_data", 32'(rd_data), 32'h0);
    check("t6_frozen", 32'(frozen), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("t6_no_ack", 32'(rd_ack), 32'h0);
    // ARMED again: a fresh match must need three more captures to freeze
    fetch(14'h200);
    fetch(14'h201);
    fetch(14'h202);
    check("t6_rearmed_post", 32'(frozen), 32'h0);
    fetch(14'h203);
    check("t6_rearmed_frozen", 32'(frozen), 32'h1);
    check("t6_fill", 32'(fill), 32'd4);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL rd_queue_drain: %0d reads outstanding, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
